// File: rtl/uart_tx_ctrl_if.sv
// Host byte handshake, frame-register hookup and serial outputs of the UART transmit sequencer.
// The master side drives bytes and returns the registered frame; the slave side is the sequencer.
interface uart_tx_ctrl_if;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [10:0] frame_data;
    logic        frame_load;
    logic [10:0] frame_q;
    logic        tx;
    logic        busy;
    logic        frame_done;

    modport master (
        output tx_data, tx_valid, frame_q,
        input  tx_ready, frame_data, frame_load, tx, busy, frame_done
    );

    modport slave (
        input  tx_data, tx_valid, frame_q,
        output tx_ready, frame_data, frame_load, tx, busy, frame_done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: latches a byte, strobes it into the external frame register,
// then shifts the registered frame out on tx at CLKS_PER_BIT clocks per bit.
//
// state | meaning
// IDLE  | line high, ready for a byte
// LOAD  | one cycle, frame register captures frame_data
// SEND  | walking frame_q[0..10] out on tx
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_ODD   = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_tx_ctrl_if.slave bus
);
    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BIT = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       data_hold_q, data_hold_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             tx_q, tx_d;
    logic             frame_done_q, frame_done_d;
    logic             parity;

    always_comb parity = (^data_hold_q) ^ (PARITY_ODD != 0);

    always_comb begin
        state_d      = state_q;
        data_hold_d  = data_hold_q;
        bit_idx_d    = bit_idx_q;
        baud_cnt_d   = baud_cnt_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    data_hold_d = bus.tx_data;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                state_d    = SEND;
                bit_idx_d  = 4'd0;
                baud_cnt_d = '0;
                // frame_q is being loaded on this same edge; the start bit is a constant 0
                tx_d       = 1'b0;
            end
            SEND: begin
                if (baud_cnt_q == CNT_LAST) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        tx_d         = 1'b1;
                    end else begin
                        bit_idx_d  = bit_idx_q + 4'd1;
                        baud_cnt_d = '0;
                        tx_d       = bus.frame_q[bit_idx_q + 4'd1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            data_hold_q  <= '0;
            bit_idx_q    <= '0;
            baud_cnt_q   <= '0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_hold_q  <= data_hold_d;
            bit_idx_q    <= bit_idx_d;
            baud_cnt_q   <= baud_cnt_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.tx_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_load = (state_q == LOAD);
    assign bus.frame_data = {1'b1, parity, data_hold_q, 1'b0};
    assign bus.tx         = tx_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: even/odd-parity sequencers at 4 clocks per bit share stimulus,
// a third at 2 clocks per bit covers the minimum baud divisor; each has its own frame register.
module tb_uart_tx_ctrl;
    logic clk;
    logic rst;
    logic [7:0] tx_data, tx_data_c;
    logic tx_valid, tx_valid_c;
    logic [10:0] fq_a, fq_b, fq_c;
    logic abort;

    int n_checks = 0;
    int n_err    = 0;

    logic [10:0] sb_a[$];
    logic [10:0] sb_b[$];

    uart_tx_ctrl_if ifa ();
    uart_tx_ctrl_if ifb ();
    uart_tx_ctrl_if ifc ();

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) u_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
    uart_tx_ctrl #(.CLKS_PER_BIT(2), .PARITY_ODD(0)) u_c (.clk_i(clk), .rst_i(rst), .bus(ifc));

    assign ifa.tx_data  = tx_data;
    assign ifa.tx_valid = tx_valid;
    assign ifb.tx_data  = tx_data;
    assign ifb.tx_valid = tx_valid;
    assign ifc.tx_data  = tx_data_c;
    assign ifc.tx_valid = tx_valid_c;
    assign ifa.frame_q  = fq_a;
    assign ifb.frame_q  = fq_b;
    assign ifc.frame_q  = fq_c;

    // reg0 stand-ins: 11-bit frame registers cleared by the same reset
    always @(posedge clk) begin
        if (rst) begin
            fq_a <= '0;
            fq_b <= '0;
            fq_c <= '0;
        end else begin
            if (ifa.frame_load) fq_a <= ifa.frame_data;
            if (ifb.frame_load) fq_b <= ifb.frame_data;
            if (ifc.frame_load) fq_c <= ifc.frame_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic odd);
        return {1'b1, (^d) ^ odd, d, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit hold, output int waited, output logic done_seen);
        logic rdy;
        bit   acc;
        acc       = 1'b0;
        waited    = 0;
        done_seen = 1'b0;
        tx_data   = d;
        tx_valid  = 1'b1;
        sb_a.push_back(mk_frame(d, 1'b0));
        sb_b.push_back(mk_frame(d, 1'b1));
        while (!acc && waited < 300) begin
            rdy       = ifa.tx_ready;
            done_seen = ifa.frame_done;
            step();
            if (rdy === 1'b1) acc = 1'b1;
            else waited++;
        end
        check("handshake", 32'(acc), 32'd1);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int  n;
        n = 0;
        while (ifa.busy !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(ifa.busy), 32'd0);
    endtask

    // Scoreboard consumer: pops at each LOAD and follows the frame bit by bit on tx.
    initial begin : mon_a
        logic [10:0] ea, eb;
        logic [3:0]  bi;
        forever begin
            @(negedge clk);
            if (ifa.frame_load === 1'b1 && !abort) begin
                ea = 11'h7FF;
                eb = 11'h7FF;
                if (sb_a.size() == 0 || sb_b.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    ea = sb_a.pop_front();
                    eb = sb_b.pop_front();
                end
                check("frame_data_a", 32'(ifa.frame_data), 32'(ea));
                check("frame_data_b", 32'(ifb.frame_data), 32'(eb));
                check("gap_tx_high", 32'({ifa.tx, ifa.tx_ready, ifa.frame_done}), 32'b100);
                for (int k = 0; k < 44 && !abort; k++) begin
                    @(negedge clk);
                    if (!abort) begin
                        bi = 4'(k / 4);
                        if (k == 0) begin
                            check("frame_q_a", 32'(fq_a), 32'(ea));
                            check("frame_q_b", 32'(fq_b), 32'(eb));
                        end
                        check("tx_a", 32'(ifa.tx), 32'(ea[bi]));
                        check("tx_b", 32'(ifb.tx), 32'(eb[bi]));
                        check("send_flags_a",
                              32'({ifa.busy, ifa.tx_ready, ifa.frame_load, ifa.frame_done}), 32'b1000);
                    end
                end
                if (!abort) begin
                    @(negedge clk);
                    check("frame_done_a",
                          32'({ifa.frame_done, ifa.tx, ifa.tx_ready, ifa.busy}), 32'b1110);
                    check("frame_done_b", 32'(ifb.frame_done), 32'd1);
                end
            end
        end
    end

    initial begin : stim
        int   w;
        logic dn;
        logic seen;
        logic rdy;
        bit   acc;
        logic [10:0] exp_c;

        rst        = 1'b1;
        abort      = 1'b0;
        tx_data    = 8'h55;
        tx_valid   = 1'b1;
        tx_data_c  = 8'h00;
        tx_valid_c = 1'b0;

        // reset held with a pending byte
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_outputs",
                  32'({ifa.tx, ifa.tx_ready, ifa.busy, ifa.frame_load, ifa.frame_done}), 32'b11000);
        end
        rst = 1'b0;

        // even parity 0x55, accepted on the first edge after release
        send(8'h55, 1'b0, w, dn);
        check("accept_after_rst", 32'(w), 32'd0);
        check("load_pulse", 32'(ifa.frame_load), 32'd1);
        step();
        check("frame_55", 32'(fq_a), 32'h4AA);
        check("load_one_cycle", 32'(ifa.frame_load), 32'd0);
        wait_idle();

        // parity selection on 0x07
        send(8'h07, 1'b0, w, dn);
        step();
        check("frame_07_even", 32'(fq_a), 32'h60E);
        check("frame_07_odd", 32'(fq_b), 32'h40E);
        wait_idle();
        step();

        // back-to-back with tx_valid held and tx_data disturbed mid-frame
        send(8'hA3, 1'b1, w, dn);
        for (int i = 0; i < 12; i++) begin
            tx_data = 8'(i * 37);
            step();
            check("ready_low_busy", 32'({ifa.tx_ready, ifa.busy}), 32'b01);
        end
        send(8'h3C, 1'b0, w, dn);
        check("b2b_in_done_cycle", 32'(dn), 32'd1);
        wait_idle();
        step();

        // mid-frame reset during bit 5
        send(8'h5A, 1'b0, w, dn);
        repeat (22) step();
        check("pre_rst_busy", 32'(ifa.busy), 32'd1);
        abort = 1'b1;
        rst   = 1'b1;
        step();
        check("rst_mid_tx_busy", 32'({ifa.tx, ifa.busy, ifa.tx_ready}), 32'b101);
        check("rst_mid_frame_q", 32'(fq_a), 32'h000);
        rst = 1'b0;
        step();
        abort = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            seen = seen | ifa.frame_done;
        end
        check("no_done_after_abort", 32'(seen), 32'd0);

        send(8'hC6, 1'b0, w, dn);
        wait_idle();
        step();
        check("sb_drained", 32'(sb_a.size()), 32'd0);

        // minimum divisor: 2 clocks per bit
        exp_c      = 11'h5FE;
        tx_data_c  = 8'hFF;
        tx_valid_c = 1'b1;
        acc        = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            rdy = ifc.tx_ready;
            step();
            if (rdy === 1'b1) acc = 1'b1;
        end
        check("c_handshake", 32'(acc), 32'd1);
        tx_valid_c = 1'b0;
        check("c_load", 32'(ifc.frame_load), 32'd1);
        step();
        check("c_frame_q", 32'(fq_c), 32'(exp_c));
        for (int k = 0; k < 22; k++) begin
            check("c_tx", 32'(ifc.tx), 32'(exp_c[4'(k / 2)]));
            check("c_bit_idx_max", 32'(u_c.bit_idx_q <= 4'd10), 32'd1);
            check("c_no_early_done", 32'({ifc.frame_done, ifc.busy}), 32'b01);
            step();
        end
        check("c_done", 32'({ifc.frame_done, ifc.tx, ifc.busy}), 32'b110);
        step();
        check("c_done_pulse", 32'(ifc.frame_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
